// File: rtl/au_cnt_gray_dn.sv
// au_cnt_gray_dn: Gray-code down counter with clear/load, zero and wrap flags,
// and a one-cycle-lagged binary view of the count.

module au_prefix_and #(
   parameter int W    = 8,
   parameter int ARCH = 0
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);
   // y[i] = &x[i:0]; ARCH picks ripple, Kogge-Stone or flat per-bit reduction.
   generate
      if (ARCH == 1) begin : g_ks
         always_comb begin
            y = x;
            for (int s = 1; s < W; s = s << 1) y = y & ~((~y) << s);
         end
      end else if (ARCH == 2) begin : g_flat
         for (genvar i = 0; i < W; i++) begin : g_bit
            assign y[i] = &x[i:0];
         end
      end else begin : g_rip
         logic acc;
         always_comb begin
            acc = 1'b1;
            y   = '0;
            for (int i = 0; i < W; i++) begin
               acc  = acc & x[i];
               y[i] = acc;
            end
         end
      end
   endgenerate
endmodule

module au_cnt_gray_dn #(
   parameter int WIDTH = 8,
   parameter int ARCH  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             zero,
   output logic             wrap,
   output logic [WIDTH-1:0] q_bin,
   output logic             bin_vld
);
   localparam logic [WIDTH-1:0] LSB = WIDTH'(1);
   localparam logic [WIDTH-1:0] MSB = LSB << (WIDTH - 1);

   logic [WIDTH-1:0] q_q, q_d, q_bin_q, q_bin_d, pa, low, flip, dec;
   logic             zero_q, zero_d, wrap_q, wrap_d, bin_vld_q;

   // pa[i] high when q[i:0] is all zero, so pa[WIDTH-1] doubles as the q == 0 test.
   au_prefix_and #(.W(WIDTH), .ARCH(ARCH)) u_pa (.x(~q_q), .y(pa));

   always_comb begin
      low  = q_q & {pa[WIDTH-2:0], 1'b1};
      flip = {low[WIDTH-2:0], 1'b0} | {low[WIDTH-1], {(WIDTH-1){1'b0}}};
      dec  = (^q_q) ? (q_q ^ LSB) : pa[WIDTH-1] ? MSB : (q_q ^ flip);
      q_d  = clr ? '0 : ld ? d : en ? dec : q_q;
      zero_d = (q_d == '0);
      wrap_d = en & ~clr & ~ld & pa[WIDTH-1];
      q_bin_d = q_q;
      for (int i = WIDTH - 2; i >= 0; i--) q_bin_d[i] = q_bin_d[i+1] ^ q_q[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q       <= '0;
         zero_q    <= 1'b1;
         wrap_q    <= 1'b0;
         q_bin_q   <= '0;
         bin_vld_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         zero_q    <= zero_d;
         wrap_q    <= wrap_d;
         q_bin_q   <= q_bin_d;
         bin_vld_q <= 1'b1;
      end
   end

   assign q       = q_q;
   assign zero    = zero_q;
   assign wrap    = wrap_q;
   assign q_bin   = q_bin_q;
   assign bin_vld = bin_vld_q;
endmodule

// File: tb/tb_au_cnt_gray_dn.sv
// tb_au_cnt_gray_dn: three WIDTH=4 counters (ARCH 0..2) and one WIDTH=2 counter
// run in lockstep against an arithmetic binary-count model.

module tb_au_cnt_gray_dn;
   logic       clk, rst_n, clr, ld, en;
   logic [3:0] d;
   logic [3:0] q4 [3];
   logic [3:0] qb4 [3];
   logic       z4 [3];
   logic       w4 [3];
   logic       v4 [3];
   logic [1:0] q2, qb2;
   logic       z2, w2, v2;

   int checks = 0;
   int errors = 0;
   bit chk_on = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      au_cnt_gray_dn #(.WIDTH(4), .ARCH(g)) u_dut (
         .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d), .en(en),
         .q(q4[g]), .zero(z4[g]), .wrap(w4[g]), .q_bin(qb4[g]), .bin_vld(v4[g])
      );
   end

   au_cnt_gray_dn #(.WIDTH(2), .ARCH(1)) u_w2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d[1:0]), .en(en),
      .q(q2), .zero(z2), .wrap(w2), .q_bin(qb2), .bin_vld(v2)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic int gray(input int b);
      return b ^ (b >> 1);
   endfunction

   function automatic int g2b(input int g);
      int b = g;
      for (int s = 1; s < 32; s = s << 1) b = b ^ (b >> s);
      return b;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state: binary counts, expected wrap / q_bin / bin_vld registers.
   int m4, m2, b4, b2;
   bit mw4, mw2, mv;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m4 <= 0; m2 <= 0; b4 <= 0; b2 <= 0; mw4 <= 0; mw2 <= 0; mv <= 0;
      end else begin
         mv  <= 1;
         b4  <= m4;
         b2  <= m2;
         mw4 <= en && !clr && !ld && m4 == 0;
         mw2 <= en && !clr && !ld && m2 == 0;
         m4  <= clr ? 0 : ld ? g2b(int'(d)) : en ? (m4 + 15) % 16 : m4;
         m2  <= clr ? 0 : ld ? g2b(int'(d[1:0])) : en ? (m2 + 3) % 4 : m2;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("q a%0d", g), q4[g], gray(m4));
            chk($sformatf("zero a%0d", g), z4[g], int'(m4 == 0));
            chk($sformatf("wrap a%0d", g), w4[g], int'(mw4));
            chk($sformatf("q_bin a%0d", g), qb4[g], b4);
            chk($sformatf("bin_vld a%0d", g), v4[g], int'(mv));
         end
         chk("q w2", q2, gray(m2));
         chk("zero w2", z2, int'(m2 == 0));
         chk("wrap w2", w2, int'(mw2));
         chk("q_bin w2", qb2, b2);
         chk("bin_vld w2", v2, int'(mv));
      end
   end

   task automatic cyc(input logic c, input logic l, input logic e, input logic [3:0] dd);
      @(negedge clk);
      clr = c; ld = l; en = e; d = dd;
      @(posedge clk);
      #1;
   endtask

   task automatic all4(input string nm, input logic [3:0] eq, input logic ez, input logic ew,
                       input logic [3:0] eqb, input logic ev);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("%s q a%0d", nm, g), q4[g], int'(eq));
         chk($sformatf("%s zero a%0d", nm, g), z4[g], int'(ez));
         chk($sformatf("%s wrap a%0d", nm, g), w4[g], int'(ew));
         chk($sformatf("%s q_bin a%0d", nm, g), qb4[g], int'(eqb));
         chk($sformatf("%s bin_vld a%0d", nm, g), v4[g], int'(ev));
      end
   endtask

   initial begin
      logic [3:0] seq [4];
      logic [3:0] prev;
      int nw;
      seq[0] = 4'b0010; seq[1] = 4'b0011; seq[2] = 4'b0001; seq[3] = 4'b0000;
      rst_n = 0; clr = 0; ld = 0; en = 0; d = 0;
      repeat (2) @(negedge clk);
      chk_on = 1;
      #1;
      all4("reset", 4'b0000, 1, 0, 4'b0000, 0);
      chk("reset zero w2", z2, 1);
      @(negedge clk);
      rst_n = 1;

      // First decrement from zero underflows to 1000.
      cyc(0, 0, 1, 0);
      all4("first dec", 4'b1000, 0, 1, 4'b0000, 1);
      chk("first dec q w2", q2, 2'b10);
      chk("first dec wrap w2", w2, 1);
      cyc(0, 0, 0, 0);
      all4("hold", 4'b1000, 0, 0, 4'b1111, 1);
      chk("hold q_bin w2", qb2, 2'b11);

      // Load 0110 then count down to zero.
      cyc(0, 1, 0, 4'b0110);
      all4("load", 4'b0110, 0, 0, 4'b1111, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 0);
         chk($sformatf("seq%0d q", i), q4[0], int'(seq[i]));
         chk($sformatf("seq%0d wrap", i), w4[0], 0);
      end
      chk("seq zero", z4[0], 1);

      // Priority: clr beats ld and en; ld beats en; no wrap on either.
      cyc(1, 1, 1, 4'b0101);
      all4("clr prio", 4'b0000, 1, 0, 4'b0000, 1);
      cyc(0, 1, 1, 4'b1000);
      all4("ld prio", 4'b1000, 0, 0, 4'b0000, 1);

      // Full 16-step cycle from 1101: one bit per step, one wrap, back to start.
      cyc(0, 1, 0, 4'b1101);
      prev = q4[0];
      nw = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 1, 0);
         chk($sformatf("onebit step%0d", i), $countones(q4[0] ^ prev), 1);
         if (i == 0) chk("lag q_bin", qb4[0], 9);
         prev = q4[0];
         nw += int'(w4[0]);
      end
      chk("cycle return", q4[0], 4'b1101);
      chk("cycle wraps", nw, 1);

      // Asynchronous reset between edges mid-count.
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      en = 0;
      #3 rst_n = 0;
      #1;
      all4("async rst", 4'b0000, 1, 0, 4'b0000, 0);
      chk("async rst q w2", q2, 0);
      chk("async rst vld w2", v2, 0);
      @(negedge clk);
      #2 rst_n = 1;
      #1;
      all4("post rel", 4'b0000, 1, 0, 4'b0000, 0);
      cyc(0, 0, 1, 0);
      all4("after rel", 4'b1000, 0, 1, 4'b0000, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
